alu_seq: RTL and testbench

Multi-cycle sequencer and status-register owner for the 20-bit ALU. Accepts one operation at a time over a valid/ready request port, drives the logic, shift/rotate and program-flow operations, and iterates shifts and rotates one bit per cycle for shift amounts 0–31. Maintains the Z/C/S status register and returns each result over a valid/ready response port. Sits between instruction decode and the ALU datapath.

---
 rtl/alu_seq_pkg.sv | 48 ++++
 rtl/alu_seq_shift.sv | 23 ++
 rtl/alu_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, status bit layout.
// The TRAP state only exists when ALU_SEQ_TRAP_EN is defined.
package alu_seq_pkg;

  localparam int WIDTH = 20;
  localparam int AMT_W = 5;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_NOT   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHR   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_ROR   = 4'd7;
  localparam logic [3:0] OP_ROL   = 4'd8;
  localparam logic [3:0] OP_LDSR  = 4'd9;
  localparam logic [3:0] OP_XORSR = 4'd10;
  localparam logic [3:0] OP_JMP   = 4'd11;
  localparam logic [3:0] OP_JZ    = 4'd12;
  localparam logic [3:0] OP_JS    = 4'd13;
  localparam logic [3:0] OP_JZS   = 4'd14;
  localparam logic [3:0] OP_TRAP  = 4'd15;

  localparam int ST_Z = 0;
  localparam int ST_C = 1;
  localparam int ST_S = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_SHIFT = 3'd2,
`ifdef ALU_SEQ_TRAP_EN
    S_TRAP  = 3'd4,
`endif
    S_DONE  = 3'd3
  } state_t;

  function automatic logic [2:0] make_status(input logic [WIDTH-1:0] res, input logic carry);
    logic [2:0] st;
    st       = '0;
    st[ST_Z] = (res == '0);
    st[ST_C] = carry;
    st[ST_S] = res[WIDTH-1];
    return st;
  endfunction

endpackage

// File: rtl/alu_seq_shift.sv
// One-bit shift/rotate step used by the sequencer's SHIFT datapath.
// Purely combinational: returns the next word and the bit that left the word.
module alu_seq_shift
  import alu_seq_pkg::*;
(
  input  logic [WIDTH-1:0] word_i,
  input  logic             left_i,
  input  logic             rotate_i,
  output logic [WIDTH-1:0] word_o,
  output logic             bit_o
);

  always_comb begin
    if (left_i) begin
      bit_o  = word_i[WIDTH-1];
      word_o = {word_i[WIDTH-2:0], rotate_i & word_i[WIDTH-1]};
    end else begin
      bit_o  = word_i[0];
      word_o = {rotate_i & word_i[0], word_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU sequencer and Z/C/S status-register owner.
// Define ALU_SEQ_TRAP_EN to make opcode 15 lock the unit in TRAP until reset.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [AMT_W-1:0] req_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic [2:0]       status,
  output logic             busy,
  output logic             trap
);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d, rsp_c_q, rsp_c_d;
  logic [AMT_W-1:0] amt_q, amt_d, cnt_q, cnt_d;
  logic [2:0]       status_q, status_d;
  logic             is_shift;
  logic [WIDTH-1:0] step_word;
  logic             step_bit;

  assign is_shift = (op_q >= OP_SHR) && (op_q <= OP_ROL);

  alu_seq_shift u_shift (
    .word_i   (work_q),
    .left_i   ((op_q == OP_SHL) || (op_q == OP_ROL)),
    .rotate_i ((op_q == OP_ROR) || (op_q == OP_ROL)),
    .word_o   (step_word),
    .bit_o    (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_EXEC;
      S_EXEC: begin
        if (is_shift && amt_q != '0) state_d = S_SHIFT;
        else                         state_d = S_DONE;
`ifdef ALU_SEQ_TRAP_EN
        if (op_q == OP_TRAP) state_d = S_TRAP;
`endif
      end
      S_SHIFT: if (cnt_q == 5'd1) state_d = S_DONE;
      S_DONE:  if (rsp_ready) state_d = S_IDLE;
`ifdef ALU_SEQ_TRAP_EN
      S_TRAP:  state_d = S_TRAP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  // Result and status only change on the way into DONE; jumps test the pre-op status.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    amt_d    = amt_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    rsp_c_d  = rsp_c_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        op_d  = req_op;
        a_d   = req_a;
        b_d   = req_b;
        amt_d = req_amt;
      end
      S_EXEC: begin
        case (op_q)
          OP_NOT: begin rsp_c_d = ~a_q;       status_d = make_status(~a_q, 1'b0);       end
          OP_AND: begin rsp_c_d = a_q & b_q;  status_d = make_status(a_q & b_q, 1'b0);  end
          OP_OR:  begin rsp_c_d = a_q | b_q;  status_d = make_status(a_q | b_q, 1'b0);  end
          OP_XOR: begin rsp_c_d = a_q ^ b_q;  status_d = make_status(a_q ^ b_q, 1'b0);  end
          OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
            if (amt_q == '0) begin
              rsp_c_d  = a_q;
              status_d = make_status(a_q, status_q[ST_C]);
            end else begin
              work_d = a_q;
              cnt_d  = amt_q;
            end
          end
          OP_LDSR:  begin rsp_c_d = a_q; status_d = a_q[2:0];            end
          OP_XORSR: begin rsp_c_d = a_q; status_d = status_q ^ a_q[2:0]; end
          OP_JMP:   rsp_c_d = b_q;
          OP_JZ:    rsp_c_d = status_q[ST_Z] ? b_q : a_q;
          OP_JS:    rsp_c_d = status_q[ST_S] ? b_q : a_q;
          OP_JZS:   rsp_c_d = (status_q[ST_Z] | status_q[ST_S]) ? b_q : a_q;
          default:  rsp_c_d = a_q;
        endcase
      end
      S_SHIFT: begin
        work_d = step_word;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          rsp_c_d  = step_word;
          status_d = make_status(step_word, step_bit);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      amt_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      rsp_c_q  <= '0;
      status_q <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      amt_q    <= amt_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      rsp_c_q  <= rsp_c_d;
      status_q <= status_d;
    end
  end

  assign rsp_c  = rsp_c_q;
  assign status = status_q;

`ifdef ALU_SEQ_TRAP_EN
  logic trap_q, trap_d;

  always_comb begin
    trap_d = trap_q;
    if (state_q == S_EXEC && op_q == OP_TRAP) trap_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_d;
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with hand-computed results, flags and latencies.
// Status vectors are written {S,C,Z}; latency counts edges after the edge preceding the request.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [19:0] req_a = '0;
  logic [19:0] req_b = '0;
  logic [4:0]  req_amt = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [19:0] rsp_c;
  logic [2:0]  status;
  logic        busy;
  logic        trap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .status    (status),
    .busy      (busy),
    .trap      (trap)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [19:0] a,
                               input logic [19:0] b, input logic [4:0] amt, input int exp_lat,
                               input logic [19:0] exp_c, input logic [2:0] exp_st, input int hold);
    int lat;
    @(posedge clk); #1;
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_amt   = amt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_c"}, 32'(rsp_c), 32'(exp_c));
    checkOutput({tag, "_st"}, 32'(status), 32'(exp_st));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold"}, 32'({rsp_valid, rsp_c}), 32'({1'b1, exp_c}));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput({tag, "_ret"}, 32'({rsp_valid, req_ready}), 32'h1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_outputs", 32'({req_ready, rsp_valid, busy, trap}), 32'h8);
    checkOutput("rst_c", 32'(rsp_c), 32'h0);
    checkOutput("rst_st", 32'(status), 32'h0);
    rst_n = 1'b1;

    applyStimulus("and",    OP_AND,   20'hF0F0F, 20'h0F0F0, 5'd0,  2,  20'h00000, 3'b001, 3);
    applyStimulus("shl1",   OP_SHL,   20'h80001, 20'h0,     5'd1,  3,  20'h00002, 3'b010, 0);
    applyStimulus("shr25",  OP_SHR,   20'h00001, 20'h0,     5'd25, 27, 20'h00000, 3'b001, 0);
    applyStimulus("ror1",   OP_ROR,   20'h00001, 20'h0,     5'd1,  3,  20'h80000, 3'b110, 0);
    applyStimulus("or",     OP_OR,    20'h80000, 20'h00001, 5'd0,  2,  20'h80001, 3'b100, 0);
    applyStimulus("not",    OP_NOT,   20'hFFFFF, 20'h0,     5'd0,  2,  20'h00000, 3'b001, 0);
    applyStimulus("rol20",  OP_ROL,   20'h12345, 20'h0,     5'd20, 22, 20'h12345, 3'b010, 1);
    applyStimulus("ldsr1",  OP_LDSR,  20'h00001, 20'h0,     5'd0,  2,  20'h00001, 3'b001, 0);
    applyStimulus("jz_t",   OP_JZ,    20'h00010, 20'h00400, 5'd0,  2,  20'h00400, 3'b001, 0);
    applyStimulus("xorsr1", OP_XORSR, 20'h00001, 20'h0,     5'd0,  2,  20'h00001, 3'b000, 0);
    applyStimulus("jzs_nt", OP_JZS,   20'h00010, 20'h00400, 5'd0,  2,  20'h00010, 3'b000, 0);
    applyStimulus("ldsr6",  OP_LDSR,  20'h00006, 20'h0,     5'd0,  2,  20'h00006, 3'b110, 0);
    applyStimulus("js_t",   OP_JS,    20'h00010, 20'h00400, 5'd0,  2,  20'h00400, 3'b110, 0);
    applyStimulus("jz_nt",  OP_JZ,    20'h00010, 20'h00400, 5'd0,  2,  20'h00010, 3'b110, 0);
    applyStimulus("shl0",   OP_SHL,   20'h00001, 20'h0,     5'd0,  2,  20'h00001, 3'b010, 0);
    applyStimulus("xorsr5", OP_XORSR, 20'h00005, 20'h0,     5'd0,  2,  20'h00005, 3'b111, 0);
    applyStimulus("nop",    OP_NOP,   20'h00055, 20'h0,     5'd0,  2,  20'h00055, 3'b111, 0);
    applyStimulus("jmp",    OP_JMP,   20'h00010, 20'h00400, 5'd0,  2,  20'h00400, 3'b111, 0);
    applyStimulus("xor",    OP_XOR,   20'h12345, 20'h12345, 5'd0,  2,  20'h00000, 3'b001, 0);
    applyStimulus("ldsr7",  OP_LDSR,  20'h00007, 20'h0,     5'd0,  2,  20'h00007, 3'b111, 0);

    // Abort an SHL by 10 during its fifth SHIFT cycle.
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = OP_SHL;
    req_a     = 20'h00001;
    req_b     = 20'h0;
    req_amt   = 5'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mid_busy", 32'({busy, rsp_valid}), 32'h2);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs", 32'({req_ready, rsp_valid, busy, trap}), 32'h8);
    checkOutput("abort_st", 32'(status), 32'h0);
    checkOutput("abort_c", 32'(rsp_c), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus("post_rst", OP_XOR, 20'hF0000, 20'h0000F, 5'd0, 2, 20'hF000F, 3'b100, 0);

`ifdef ALU_SEQ_TRAP_EN
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = OP_TRAP;
    req_a     = 20'h00321;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      checkOutput("trap_hold", 32'({trap, req_ready, rsp_valid}), 32'h4);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("trap_rst", 32'({trap, req_ready}), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
`else
    applyStimulus("op15_nop", OP_TRAP, 20'h00321, 20'h00400, 5'd0, 2, 20'h00321, 3'b100, 0);
    checkOutput("op15_trap", 32'(trap), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
